// File: rtl/forwarding.sv
// Last-stage forwarding record published to earlier stages.
package forwarding;

    typedef struct packed {
        logic        data_valid;
        logic [4:0]  address;
        logic [31:0] data;
    } t;

endpackage

// File: rtl/instruction.sv
// Decoded-instruction view as seen by the last pipeline stage.
package instruction;

    typedef enum logic [3:0] {
        OP_ALU     = 4'd0,
        OP_ALU_IMM = 4'd1,
        OP_LUI     = 4'd2,
        OP_AUIPC   = 4'd3,
        OP_LOAD    = 4'd4,
        OP_STORE   = 4'd5,
        OP_BRANCH  = 4'd6,
        OP_JAL     = 4'd7,
        OP_JALR    = 4'd8,
        OP_FENCE   = 4'd9,
        OP_SYSTEM  = 4'd10
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [4:0] rd_address;
    } t;

    function automatic logic writes_rd(op_t op);
        logic result;
        case (op)
            OP_STORE, OP_BRANCH, OP_FENCE, OP_SYSTEM: result = 1'b0;
            default:                                  result = 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/pipeline_status.sv
// Pipeline status codes exchanged between stages, plus the exception-to-mcause mapping.
package pipeline_status;

    typedef enum logic [2:0] {
        VALID               = 3'd0,
        BUBBLE              = 3'd1,
        ILLEGAL_INSTRUCTION = 3'd2,
        BREAKPOINT          = 3'd3,
        LOAD_MISALIGNED     = 3'd4,
        STORE_MISALIGNED    = 3'd5,
        ECALL               = 3'd6
    } forwards_t;

    typedef enum logic [1:0] {
        READY = 2'd0,
        STALL = 2'd1,
        JUMP  = 2'd2
    } backwards_t;

    function automatic logic [31:0] to_mcause(forwards_t status);
        logic [31:0] cause;
        case (status)
            ILLEGAL_INSTRUCTION: cause = 32'd2;
            BREAKPOINT:          cause = 32'd3;
            LOAD_MISALIGNED:     cause = 32'd4;
            STORE_MISALIGNED:    cause = 32'd6;
            ECALL:               cause = 32'd11;
            default:             cause = 32'd0;
        endcase
        return cause;
    endfunction

endpackage

// File: rtl/writeback_stage_pkg.sv
// Local types and defaults for the writeback stage.
package writeback_stage_pkg;

    import pipeline_status::*;

    localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;
    localparam int          DEFAULT_COUNTER_W   = 64;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } wb_state_t;

    function automatic logic is_exception(forwards_t status);
        return (status != VALID) && (status != BUBBLE);
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage to writeback-stage bus, including the register-file write and forwarding.
interface writeback_stage_if;

    logic [31:0]                rd_data_in;
    instruction::t              instruction_in;
    logic [31:0]                program_counter_in;
    pipeline_status::forwards_t status_forwards_in;

    pipeline_status::backwards_t status_backwards_out;
    logic [31:0]                 jump_address_backwards_out;

    logic                        rd_write_enable_out;
    logic [4:0]                  rd_address_out;
    logic [31:0]                 rd_data_out;
    forwarding::t                forwarding_out;

    modport master (
        output rd_data_in, instruction_in, program_counter_in, status_forwards_in,
        input  status_backwards_out, jump_address_backwards_out,
               rd_write_enable_out, rd_address_out, rd_data_out, forwarding_out
    );

    modport slave (
        input  rd_data_in, instruction_in, program_counter_in, status_forwards_in,
        output status_backwards_out, jump_address_backwards_out,
               rd_write_enable_out, rd_address_out, rd_data_out, forwarding_out
    );

endinterface

// File: rtl/wb_counters.sv
// Free-running cycle counter and retired-instruction counter, both wrapping.
module wb_counters #(
    parameter int COUNTER_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 retire,
    output logic [COUNTER_W-1:0] cycle_count,
    output logic [COUNTER_W-1:0] instret_count
);

    logic [COUNTER_W-1:0] cycle_count_reg;
    logic [COUNTER_W-1:0] instret_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_reg   <= '0;
            instret_count_reg <= '0;
        end else begin
            cycle_count_reg <= cycle_count_reg + 1'b1;
            if (retire) begin
                instret_count_reg <= instret_count_reg + 1'b1;
            end
        end
    end

    assign cycle_count   = cycle_count_reg;
    assign instret_count = instret_count_reg;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: register-file commit, forwarding, retire counting and trap redirect.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR,
    parameter int          COUNTER_W   = DEFAULT_COUNTER_W
) (
    input  logic                 clk,
    input  logic                 rst,
    writeback_stage_if.slave     wb,
    output logic [31:0]          mepc_out,
    output logic [31:0]          mcause_out,
    output logic [COUNTER_W-1:0] cycle_count_out,
    output logic [COUNTER_W-1:0] instret_count_out,
    output logic                 trap_pending_out
);

    wb_state_t   state_reg;
    wb_state_t   state_next;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic        commit;
    logic        capture_en;
    logic        write_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_RUN;
            mepc_reg   <= '0;
            mcause_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (capture_en) begin
                mepc_reg   <= wb.program_counter_in;
                mcause_reg <= pipeline_status::to_mcause(wb.status_forwards_in);
            end
        end
    end

    // TRAP lasts one cycle and squashes whatever arrives, exceptions included.
    always_comb begin
        state_next = state_reg;
        commit     = 1'b0;
        capture_en = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (wb.status_forwards_in == pipeline_status::VALID) begin
                    commit = 1'b1;
                end else if (is_exception(wb.status_forwards_in)) begin
                    capture_en = 1'b1;
                    state_next = ST_TRAP;
                end
            end
            ST_TRAP: state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    assign write_en = commit
                    && instruction::writes_rd(wb.instruction_in.op)
                    && (wb.instruction_in.rd_address != 5'd0);

    always_comb begin
        wb.rd_write_enable_out = write_en;
        wb.rd_address_out      = wb.instruction_in.rd_address;
        wb.rd_data_out         = wb.rd_data_in;
        wb.forwarding_out      = '0;
        if (write_en) begin
            wb.forwarding_out.data_valid = 1'b1;
            wb.forwarding_out.address    = wb.instruction_in.rd_address;
            wb.forwarding_out.data       = wb.rd_data_in;
        end
    end

    // The redirect comes straight off the state register, so it is registered by construction.
    always_comb begin
        wb.status_backwards_out       = pipeline_status::READY;
        wb.jump_address_backwards_out = '0;
        trap_pending_out              = 1'b0;
        if (state_reg == ST_TRAP) begin
            wb.status_backwards_out       = pipeline_status::JUMP;
            wb.jump_address_backwards_out = TRAP_VECTOR;
            trap_pending_out              = 1'b1;
        end
    end

    wb_counters #(
        .COUNTER_W(COUNTER_W)
    ) u_counters (
        .clk          (clk),
        .rst          (rst),
        .retire       (commit),
        .cycle_count  (cycle_count_out),
        .instret_count(instret_count_out)
    );

    assign mepc_out   = mepc_reg;
    assign mcause_out = mcause_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage; inputs change and outputs are sampled on the falling edge.
module tb_writeback_stage;

    import pipeline_status::*;
    import instruction::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] cycle_count;
    logic [63:0] instret_count;
    logic        trap_pending;

    int          vec_count  = 0;
    int          miscompares = 0;
    logic [63:0] exp_cycle  = '0;
    forwarding::t exp_fwd;

    writeback_stage_if wbi ();

    writeback_stage #(
        .TRAP_VECTOR(32'h0000_0100),
        .COUNTER_W  (64)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wb               (wbi.slave),
        .mepc_out         (mepc),
        .mcause_out       (mcause),
        .cycle_count_out  (cycle_count),
        .instret_count_out(instret_count),
        .trap_pending_out (trap_pending)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic drive(input forwards_t st, input op_t op, input logic [4:0] rd,
                         input logic [31:0] data, input logic [31:0] pc);
        wbi.status_forwards_in = st;
        wbi.instruction_in     = '{op: op, rd_address: rd};
        wbi.rd_data_in         = data;
        wbi.program_counter_in = pc;
    endtask

    // Advance one clock; the expected cycle count follows reset as sampled at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) exp_cycle = '0;
        else     exp_cycle = exp_cycle + 64'd1;
        @(negedge clk);
    endtask

    initial begin
        drive(BUBBLE, OP_ALU, 5'd0, 32'h0, 32'h0);
        tick();
        tick();

        // Reset state
        check_val("rst_status", 64'(wbi.status_backwards_out), 64'(READY));
        check_val("rst_jump", 64'(wbi.jump_address_backwards_out), 64'h0);
        check_val("rst_we", 64'(wbi.rd_write_enable_out), 64'h0);
        check_val("rst_fwd", 64'(wbi.forwarding_out), 64'h0);
        check_val("rst_trap", 64'(trap_pending), 64'h0);
        check_val("rst_mepc", 64'(mepc), 64'h0);
        check_val("rst_mcause", 64'(mcause), 64'h0);
        check_val("rst_cycle", cycle_count, 64'h0);
        check_val("rst_instret", instret_count, 64'h0);

        rst = 1'b0;
        tick();

        // 1: VALID ADDI x5
        drive(VALID, OP_ALU_IMM, 5'd5, 32'h0000_1234, 32'h10);
        #1;
        exp_fwd = '{data_valid: 1'b1, address: 5'd5, data: 32'h0000_1234};
        check_val("t1_we", 64'(wbi.rd_write_enable_out), 64'h1);
        check_val("t1_addr", 64'(wbi.rd_address_out), 64'h5);
        check_val("t1_data", 64'(wbi.rd_data_out), 64'h1234);
        check_val("t1_fwd", 64'(wbi.forwarding_out), 64'(exp_fwd));
        check_val("t1_instret_before", instret_count, 64'h0);
        tick();
        check_val("t1_instret_after", instret_count, 64'h1);
        check_val("t1_cycle", cycle_count, exp_cycle);

        // 2: VALID ADD rd=x0 retires without writing
        drive(VALID, OP_ALU, 5'd0, 32'hDEAD_BEEF, 32'h14);
        #1;
        check_val("t2_we", 64'(wbi.rd_write_enable_out), 64'h0);
        check_val("t2_fwd", 64'(wbi.forwarding_out), 64'h0);
        tick();
        check_val("t2_instret", instret_count, 64'h2);

        // Store retires but never writes rd
        drive(VALID, OP_STORE, 5'd7, 32'h0000_0077, 32'h18);
        #1;
        check_val("st_we", 64'(wbi.rd_write_enable_out), 64'h0);
        tick();
        check_val("st_instret", instret_count, 64'h3);

        // Bubble: nothing happens
        drive(BUBBLE, OP_ALU_IMM, 5'd5, 32'h0000_5555, 32'h1C);
        #1;
        check_val("bub_we", 64'(wbi.rd_write_enable_out), 64'h0);
        tick();
        check_val("bub_instret", instret_count, 64'h3);

        // 3: illegal instruction at 0x80
        drive(ILLEGAL_INSTRUCTION, OP_ALU_IMM, 5'd9, 32'h0000_0999, 32'h80);
        #1;
        check_val("t3_we", 64'(wbi.rd_write_enable_out), 64'h0);
        check_val("t3_status_same_cycle", 64'(wbi.status_backwards_out), 64'(READY));
        tick();
        drive(BUBBLE, OP_ALU, 5'd0, 32'h0, 32'h0);
        check_val("t3_status", 64'(wbi.status_backwards_out), 64'(JUMP));
        check_val("t3_jump", 64'(wbi.jump_address_backwards_out), 64'h100);
        check_val("t3_mepc", 64'(mepc), 64'h80);
        check_val("t3_mcause", 64'(mcause), 64'd2);
        check_val("t3_trap", 64'(trap_pending), 64'h1);
        check_val("t3_instret", instret_count, 64'h3);
        tick();
        check_val("t3_status_after", 64'(wbi.status_backwards_out), 64'(READY));
        check_val("t3_jump_after", 64'(wbi.jump_address_backwards_out), 64'h0);
        check_val("t3_trap_after", 64'(trap_pending), 64'h0);

        // 4: ECALL then VALID ADDI x6 squashed in the TRAP cycle
        drive(ECALL, OP_SYSTEM, 5'd0, 32'h0, 32'h200);
        tick();
        drive(VALID, OP_ALU_IMM, 5'd6, 32'h0000_0066, 32'h204);
        #1;
        check_val("t4_we", 64'(wbi.rd_write_enable_out), 64'h0);
        check_val("t4_fwd", 64'(wbi.forwarding_out), 64'h0);
        tick();
        check_val("t4_instret", instret_count, 64'h3);
        check_val("t4_mepc", 64'(mepc), 64'h200);
        check_val("t4_mcause", 64'd11, 64'(mcause));
        check_val("t4_status", 64'(wbi.status_backwards_out), 64'(READY));

        // Exception inside TRAP is not captured and does not re-trap
        drive(LOAD_MISALIGNED, OP_LOAD, 5'd3, 32'h0, 32'h300);
        tick();
        drive(BREAKPOINT, OP_SYSTEM, 5'd0, 32'h0, 32'h400);
        tick();
        drive(BUBBLE, OP_ALU, 5'd0, 32'h0, 32'h0);
        check_val("tt_mepc", 64'(mepc), 64'h300);
        check_val("tt_mcause", 64'(mcause), 64'd4);
        check_val("tt_status", 64'(wbi.status_backwards_out), 64'(READY));

        // 5: instret wraps
        force dut.u_counters.instret_count_reg = {64{1'b1}};
        #1;
        release dut.u_counters.instret_count_reg;
        check_val("t5_preload", instret_count, {64{1'b1}});
        drive(VALID, OP_ALU_IMM, 5'd1, 32'h0000_0001, 32'h500);
        tick();
        check_val("t5_instret_wrap", instret_count, 64'h0);
        check_val("t5_cycle", cycle_count, exp_cycle);

        // 6: reset while in TRAP
        drive(STORE_MISALIGNED, OP_STORE, 5'd0, 32'h0, 32'h600);
        tick();
        drive(BUBBLE, OP_ALU, 5'd0, 32'h0, 32'h0);
        check_val("t6_trap_status", 64'(wbi.status_backwards_out), 64'(JUMP));
        check_val("t6_mcause", 64'(mcause), 64'd6);
        rst = 1'b1;
        tick();
        check_val("t6_status", 64'(wbi.status_backwards_out), 64'(READY));
        check_val("t6_jump", 64'(wbi.jump_address_backwards_out), 64'h0);
        check_val("t6_mepc", 64'(mepc), 64'h0);
        check_val("t6_mcause", 64'(mcause), 64'h0);
        check_val("t6_cycle", cycle_count, 64'h0);
        check_val("t6_instret", instret_count, 64'h0);
        check_val("t6_trap", 64'(trap_pending), 64'h0);
        rst = 1'b0;
        tick();
        tick();
        check_val("t6_cycle_restart", cycle_count, exp_cycle);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
